// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one block-wide memory port between
// the I-cache (client 0) and the D-cache (client 1). One transaction in flight;
// reads that the memory never answers are aborted by a watchdog count.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int BLOCK_SIZE     = 128,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*BLOCK_SIZE-1:0] req_wdata,
   output logic [1:0]              gnt,
   output logic [1:0]              done,
   output logic                    err,
   output logic [BLOCK_SIZE-1:0]   rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [BLOCK_SIZE-1:0]   mem_wdata,
   input  logic                    mem_ready,
   input  logic                    mem_valid,
   input  logic [BLOCK_SIZE-1:0]   mem_rdata
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_RD = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, cnt_nxt;
   logic                  ptr_q, ptr_d;        // last granted client
   logic                  abort_q, abort_d;    // current transaction timed out
   logic [BLOCK_SIZE-1:0] rbuf_q, rbuf_d;      // captured refill block
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            done_q, done_d;
   logic                  err_q, err_d;
   logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [BLOCK_SIZE-1:0] mem_wdata_q, mem_wdata_d;
   logic                  win;

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   // Next-state: arbitration in IDLE, memory handshake, watchdog and response pulse.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      abort_d     = abort_q;
      rbuf_d      = rbuf_q;
      gnt_d       = gnt_q;
      done_d      = 2'b00;
      err_d       = 1'b0;
      rdata_d     = '0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_nxt     = cnt_q + CW'(1);
      // Client 1 wins when alone, or when both ask and client 0 went last.
      win         = req[1] & (~req[0] | ~ptr_q);

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               gnt_d       = win ? 2'b10 : 2'b01;
               ptr_d       = win;
               mem_we_d    = req_we[win];
               mem_addr_d  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
               if (req_we[win])
                  mem_wdata_d = win ? req_wdata[2*BLOCK_SIZE-1:BLOCK_SIZE] : req_wdata[BLOCK_SIZE-1:0];
               else
                  mem_wdata_d = '0;
               mem_req_d   = 1'b1;
               cnt_d       = '0;
               abort_d     = 1'b0;
               rbuf_d      = '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_nxt;
            // An accepted write is complete; an accepted read on the last
            // allowed cycle still has no data, so the watchdog wins over it.
            if (mem_ready && mem_we_q) begin
               mem_req_d = 1'b0;
               state_d   = S_RESP;
            end else if (cnt_nxt == CNT_MAX) begin
               mem_req_d = 1'b0;
               abort_d   = 1'b1;
               state_d   = S_RESP;
            end else if (mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = S_WAIT_RD;
            end
         end
         S_WAIT_RD: begin
            cnt_d = cnt_nxt;
            if (mem_valid) begin
               rbuf_d  = mem_rdata;
               state_d = S_RESP;
            end else if (cnt_nxt == CNT_MAX) begin
               abort_d = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // rbuf stays zero for writes and aborted reads.
            done_d  = gnt_q;
            err_d   = abort_q;
            rdata_d = rbuf_q;
            gnt_d   = 2'b00;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ptr_q       <= 1'b1;
         abort_q     <= 1'b0;
         rbuf_q      <= '0;
         gnt_q       <= 2'b00;
         done_q      <= 2'b00;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         abort_q     <= abort_d;
         rbuf_q      <= rbuf_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule
